// File: rtl/gmii_rx_arbiter.sv
// gmii_rx_arbiter: merges two GMII receive decoder word streams into one
// shared pixel-FIFO write port. Each channel owns a small elastic buffer;
// a word-granular round-robin arbiter drains both and tags each word with
// its source channel in the MSB of fifo_din. When a buffer overflows, the
// rest of that packet is discarded so no partial packet tail reaches the FIFO.
// Optional feature macro: GMII_ARB_DROP_CNT_EN implements the saturating
// per-channel drop counters; without it ch0_drop_cnt/ch1_drop_cnt read 0.
module gmii_rx_arbiter #(
  parameter int DATA_W = 29,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk125,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] ch0_datain,
  input  logic              ch0_recv_en,
  input  logic              ch0_packet_en,
  input  logic [DATA_W-1:0] ch1_datain,
  input  logic              ch1_recv_en,
  input  logic              ch1_packet_en,
  input  logic              fifo_full,
  output logic [DATA_W:0]   fifo_din,
  output logic              fifo_wr_en,
  output logic [CNT_W-1:0]  ch0_drop_cnt,
  output logic [CNT_W-1:0]  ch1_drop_cnt,
  output logic              ch0_discard,
  output logic              ch1_discard
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] datain [2];
  logic [1:0]        recv_en;
  logic [1:0]        packet_en;

  assign datain[0] = ch0_datain;
  assign datain[1] = ch1_datain;
  assign recv_en   = {ch1_recv_en, ch0_recv_en};
  assign packet_en = {ch1_packet_en, ch0_packet_en};

  logic [DATA_W-1:0] buf_mem [2][DEPTH];
  logic [AW:0]       wr_ptr [2];
  logic [AW:0]       rd_ptr [2];
  logic [1:0]        buf_empty;
  logic [1:0]        buf_full;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        blocked;
  logic [1:0]        ovf;
  logic [1:0]        discard_q;
  logic [1:0]        discard_nxt;
  logic              gnt_vld;
  logic              gnt_id;
  logic              last_grant;
  logic [DATA_W-1:0] head_word;

  // Buffer occupancy flags from the extra-MSB pointer comparison
  always_comb begin
    buf_empty = '0;
    buf_full  = '0;
    for (int c = 0; c < 2; c++) begin
      buf_empty[c] = (wr_ptr[c] == rd_ptr[c]);
      buf_full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                     (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
    end
  end

  // Round-robin grant: a lone non-empty buffer wins, a tie goes to the channel not served last
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!fifo_full) begin
      if (!buf_empty[0] && !buf_empty[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end else if (!buf_empty[0]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (!buf_empty[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    head_word = buf_mem[gnt_id][rd_ptr[gnt_id][AW-1:0]];
  end

  // Push/pop decisions and discard-state update for each channel
  always_comb begin
    pop         = '0;
    push        = '0;
    blocked     = '0;
    ovf         = '0;
    discard_nxt = '0;
    pop[gnt_id] = gnt_vld;
    for (int c = 0; c < 2; c++) begin
      // A discarding channel keeps dropping until packet_en is seen low;
      // the low cycle itself already accepts a word.
      blocked[c]     = discard_q[c] & packet_en[c];
      push[c]        = recv_en[c] & ~blocked[c] & (~buf_full[c] | pop[c]);
      ovf[c]         = recv_en[c] & ~blocked[c] & buf_full[c] & ~pop[c];
      discard_nxt[c] = ovf[c] | blocked[c];
    end
  end

  // Buffer storage (data only, not reset)
  always_ff @(posedge clk125) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) buf_mem[c][wr_ptr[c][AW-1:0]] <= datain[c];
    end
  end

  // Buffer pointers and discard flags
  always_ff @(posedge clk125) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      discard_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
      end
      discard_q <= discard_nxt;
    end
  end

  // Shared FIFO write register and round-robin history
  always_ff @(posedge clk125) begin
    if (!sys_rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      last_grant <= 1'b1;
    end else begin
      fifo_wr_en <= gnt_vld;
      if (gnt_vld) begin
        fifo_din   <= {gnt_id, head_word};
        last_grant <= gnt_id;
      end
    end
  end

  assign ch0_discard = discard_q[0];
  assign ch1_discard = discard_q[1];

`ifdef GMII_ARB_DROP_CNT_EN
  logic [1:0]       drop;
  logic [CNT_W-1:0] drop_cnt [2];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign drop = recv_en & ~push;

  // Saturating dropped-word counters, cleared only by reset
  always_ff @(posedge clk125) begin
    if (!sys_rst_n) begin
      drop_cnt[0] <= '0;
      drop_cnt[1] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (drop[c]) drop_cnt[c] <= sat_inc(drop_cnt[c]);
      end
    end
  end

  assign ch0_drop_cnt = drop_cnt[0];
  assign ch1_drop_cnt = drop_cnt[1];
`else
  assign ch0_drop_cnt = '0;
  assign ch1_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_arbiter.sv
// Bench for gmii_rx_arbiter: directed scenarios plus randomized traffic,
// scored against a queue-based behavioural model of the merge rules.
module tb_gmii_rx_arbiter;

  localparam int DATA_W = 29;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
`ifdef GMII_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk125 = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DATA_W-1:0] ch0_datain = '0;
  logic              ch0_recv_en = 1'b0;
  logic              ch0_packet_en = 1'b0;
  logic [DATA_W-1:0] ch1_datain = '0;
  logic              ch1_recv_en = 1'b0;
  logic              ch1_packet_en = 1'b0;
  logic              fifo_full = 1'b0;
  logic [DATA_W:0]   fifo_din;
  logic              fifo_wr_en;
  logic [CNT_W-1:0]  ch0_drop_cnt;
  logic [CNT_W-1:0]  ch1_drop_cnt;
  logic              ch0_discard;
  logic              ch1_discard;

  always #4 clk125 = ~clk125;

  gmii_rx_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk125(clk125), .sys_rst_n(sys_rst_n),
    .ch0_datain(ch0_datain), .ch0_recv_en(ch0_recv_en), .ch0_packet_en(ch0_packet_en),
    .ch1_datain(ch1_datain), .ch1_recv_en(ch1_recv_en), .ch1_packet_en(ch1_packet_en),
    .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .ch0_drop_cnt(ch0_drop_cnt), .ch1_drop_cnt(ch1_drop_cnt),
    .ch0_discard(ch0_discard), .ch1_discard(ch1_discard)
  );

  // Reference model state: per-channel buffer contents as queues
  logic [DATA_W-1:0] mq0[$];
  logic [DATA_W-1:0] mq1[$];
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   mdin;
  bit                md [2];
  int                mdrop [2];
  bit                mlast;

  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  int wr_cnt [2];
  bit saw_disc0 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One channel's arrival rule; sz is occupancy after this cycle's pop
  task automatic chan_rule(input int c, input bit rv, input bit pk, input int sz, output bit acc);
    bit blk;
    blk = md[c] && pk;
    acc = rv && !blk && (sz < DEPTH);
    if (rv && !acc && mdrop[c] < (1 << CNT_W) - 1) mdrop[c]++;
    if (rv && !blk && !acc) md[c] = 1'b1;
    else if (!pk) md[c] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit g, gid, acc;
    logic [DATA_W-1:0] w;
    if (!sys_rst_n) begin
      mq0.delete();
      mq1.delete();
      md[0] = 0; md[1] = 0;
      mdrop[0] = 0; mdrop[1] = 0;
      mlast = 1'b1;
      mdin = '0;
      return;
    end
    g = 0; gid = 0;
    if (!fifo_full) begin
      if (mq0.size() > 0 && mq1.size() > 0) begin g = 1; gid = ~mlast; end
      else if (mq0.size() > 0) begin g = 1; gid = 0; end
      else if (mq1.size() > 0) begin g = 1; gid = 1; end
    end
    if (g) begin
      w = gid ? mq1.pop_front() : mq0.pop_front();
      mdin = {gid, w};
      exp_q.push_back(mdin);
      mlast = gid;
    end
    chan_rule(0, ch0_recv_en, ch0_packet_en, mq0.size(), acc);
    if (acc) mq0.push_back(ch0_datain);
    chan_rule(1, ch1_recv_en, ch1_packet_en, mq1.size(), acc);
    if (acc) mq1.push_back(ch1_datain);
  endtask

  task automatic step(input bit rstn, input bit ff,
                      input bit r0, input bit p0, input logic [DATA_W-1:0] d0,
                      input bit r1, input bit p1, input logic [DATA_W-1:0] d1);
    sys_rst_n = rstn; fifo_full = ff;
    ch0_recv_en = r0; ch0_packet_en = p0; ch0_datain = d0;
    ch1_recv_en = r1; ch1_packet_en = p1; ch1_datain = d1;
    model_step();
    @(posedge clk125);
    #2;
  endtask

  task automatic idle(input int n, input bit ff);
    for (int i = 0; i < n; i++) step(1, ff, 0, 0, '0, 0, 0, '0);
  endtask

  // Monitor: sample #1 after each edge and score against the model
  initial begin
    logic [DATA_W:0] e;
    forever begin
      @(posedge clk125);
      #1;
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_en_expected", fifo_wr_en, 1);
          chk("fifo_din", fifo_din, e);
        end else begin
          chk("wr_en_idle", fifo_wr_en, 0);
          chk("din_hold", fifo_din, mdin);
        end
        if (fifo_wr_en === 1'b1) wr_cnt[fifo_din[DATA_W]]++;
        chk("ch0_discard", ch0_discard, md[0]);
        chk("ch1_discard", ch1_discard, md[1]);
        chk("ch0_drop_cnt", ch0_drop_cnt, CNT_EN ? mdrop[0] : 0);
        chk("ch1_drop_cnt", ch1_drop_cnt, CNT_EN ? mdrop[1] : 0);
        if (ch0_discard === 1'b1) saw_disc0 = 1'b1;
      end
    end
  end

  // Random traffic generator state
  bit rpk [2];
  int rlen [2];
  int rgap [2];
  bit rr [2];
  logic [DATA_W-1:0] rd [2];
  bit rff;
  int rhold;
  int b0, b1;
  logic [DATA_W-1:0] wa, wb;

  initial begin
    wr_cnt[0] = 0; wr_cnt[1] = 0;

    // Reset state
    step(0, 0, 0, 0, '0, 0, 0, '0);
    mon_en = 1'b1;
    step(0, 0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, '0, 0, 0, '0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_drop0", ch0_drop_cnt, 0);
    chk("rst_disc1", ch1_discard, 0);

    // Single word with two-clock latency
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    step(1, 0, 1, 1, 29'h0ABCDEF1, 0, 0, '0);
    chk("single_not_early", fifo_wr_en, 0);
    step(1, 0, 0, 1, '0, 0, 0, '0);
    chk("single_latency", fifo_wr_en, 1);
    chk("single_din", fifo_din, 30'h0ABCDEF1);
    idle(6, 0);
    chk("single_ch0_count", wr_cnt[0] - b0, 1);
    chk("single_ch1_count", wr_cnt[1] - b1, 0);

    // Tie right after reset: channel 0 first
    step(0, 0, 0, 0, '0, 0, 0, '0);
    wa = 29'h1234567; wb = 29'h0FEDCBA;
    step(1, 0, 1, 1, wa, 1, 1, wb);
    step(1, 0, 0, 1, '0, 0, 1, '0);
    chk("tie_first", fifo_din, {1'b0, wa});
    step(1, 0, 0, 0, '0, 0, 0, '0);
    chk("tie_second", fifo_din, {1'b1, wb});
    idle(3, 0);

    // Interleave: 640 words per channel, phase aligned
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    for (int i = 0; i < 1280; i++) begin
      if (i % 2 == 0) step(1, 0, 1, 1, DATA_W'(i * 7 + 3), 1, 1, DATA_W'(i * 13 + 5));
      else            step(1, 0, 0, 1, '0, 0, 1, '0);
    end
    idle(4, 0);
    chk("ilv_ch0_count", wr_cnt[0] - b0, 640);
    chk("ilv_ch1_count", wr_cnt[1] - b1, 640);
    chk("ilv_drop0", ch0_drop_cnt, 0);
    chk("ilv_drop1", ch1_drop_cnt, 0);

    // Overflow and discard on channel 0
    b0 = wr_cnt[0];
    saw_disc0 = 1'b0;
    for (int t = 0; t < 40; t++)
      step(1, (t >= 10 && t <= 21), (t % 2 == 0), 1, DATA_W'($urandom), 0, 0, '0);
    chk("ovf_discard_seen", saw_disc0, 1);
    chk("ovf_drop_cnt", ch0_drop_cnt, CNT_EN ? 11 : 0);
    step(1, 0, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, 0, '0, 0, 0, '0);
    chk("ovf_discard_clear", ch0_discard, 0);
    for (int t = 0; t < 16; t++)
      step(1, 0, (t % 2 == 0), 1, DATA_W'($urandom), 0, 0, '0);
    idle(6, 0);
    chk("ovf_ch0_count", wr_cnt[0] - b0, 17);

    // Reset while both buffers hold three words
    for (int t = 0; t < 6; t++)
      step(1, 1, (t % 2 == 0), 1, DATA_W'($urandom), (t % 2 == 0), 1, DATA_W'($urandom));
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    step(0, 0, 0, 0, '0, 0, 0, '0);
    idle(8, 0);
    chk("rst_mid_writes", (wr_cnt[0] - b0) + (wr_cnt[1] - b1), 0);
    chk("rst_mid_din", fifo_din, 0);
    chk("rst_mid_drop0", ch0_drop_cnt, 0);
    chk("rst_mid_disc0", ch0_discard, 0);

    // Randomized traffic with backpressure bursts
    for (int c = 0; c < 2; c++) begin rpk[c] = 0; rlen[c] = 0; rgap[c] = 1; end
    rff = 0; rhold = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!rpk[c]) begin
          if ($urandom_range(0, 9) == 0) begin rpk[c] = 1; rlen[c] = $urandom_range(4, 40); end
        end else begin
          rlen[c]--;
          if (rlen[c] == 0) rpk[c] = 0;
        end
        rr[c] = 0;
        if (rgap[c] >= 1) begin
          if (rpk[c] && $urandom_range(0, 2) != 0) rr[c] = 1;
          else if (!rpk[c] && $urandom_range(0, 29) == 0) rr[c] = 1;
        end
        if (rr[c]) rgap[c] = 0; else rgap[c]++;
        rd[c] = DATA_W'($urandom);
      end
      if (rhold == 0) begin
        rff = ($urandom_range(0, 3) == 0);
        rhold = $urandom_range(1, 15);
      end
      rhold--;
      step(1, rff, rr[0], rpk[0], rd[0], rr[1], rpk[1], rd[1]);
    end
    idle(20, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gmii_rx_arbiter.md
# gmii_rx_arbiter

Shares one pixel-FIFO write port between two GMII receive decoders (channel 0 and channel 1, each producing 29-bit `{x, y, YUV}` words with a `recv_en` strobe and a `packet_en` window). Each channel gets a small elastic buffer. A word-granular round-robin arbiter drains both buffers into the shared FIFO and tags every word with its source channel. On buffer overflow, the rest of the affected packet is discarded so the FIFO never receives a partial packet tail.

## Interface

Parameters:
- `DATA_W`, 29: width of one decoder word.
- `DEPTH`, 4: entries per channel buffer; power of two, ≥2.
- `CNT_W`, 16: width of each drop counter.

Ports:
- `clk125` in 1: 125 MHz GMII receive clock; the only clock.
- `sys_rst_n` in 1: synchronous, active-low reset, sampled on `clk125` rising edge.
- `ch0_datain` in DATA_W: channel 0 word.
- `ch0_recv_en` in 1: channel 0 word valid, single-cycle strobe.
- `ch0_packet_en` in 1: channel 0 packet window, high for the whole payload.
- `ch1_datain`, `ch1_recv_en`, `ch1_packet_en`: same as channel 0, for channel 1.
- `fifo_full` in 1: shared FIFO full / programmable-full.
- `fifo_din` out DATA_W+1: `{channel_id, word}`.
- `fifo_wr_en` out 1: one-cycle write strobe for `fifo_din`.
- `ch0_drop_cnt` out CNT_W: channel 0 dropped-word count.
- `ch1_drop_cnt` out CNT_W: channel 1 dropped-word count.
- `ch0_discard`, `ch1_discard` out 1: channel is in packet-discard state.

## Operation

Per-channel buffer (FIFO, DEPTH entries, read/write pointers one bit wider than the address):
- Push condition: `recv_en`, discard clear, and the buffer is not full or is being popped this cycle.
- `recv_en` while full with no pop: word dropped, `discard` set, drop counter +1.
- While `discard` is set, every `recv_en` word is dropped and counted.
- `discard` clears on the first cycle `packet_en` is sampled low. A new packet is then accepted normally.

Arbiter:
- Evaluated every cycle. No grant while `fifo_full`=1.
- One buffer non-empty: that buffer is granted.
- Both buffers non-empty: the channel not equal to `last_grant` is granted.
- `last_grant` updates only on an actual grant.
- On a grant, the head entry is popped and `fifo_din <= {id, word}`, `fifo_wr_en <= 1`.
- Otherwise `fifo_wr_en <= 0` and `fifo_din` holds its value.
- Per-channel word order is preserved. Channels interleave at word granularity.
- Each decoder emits at most one word per 2 cycles, so aggregate demand (≤1 word/cycle) never exceeds drain rate while `fifo_full`=0. Drops occur only under FIFO backpressure.

Drop counters:
- Saturate at all-ones.
- Cleared only by reset.

## Timing

- Reset values:
  - `fifo_din`=0, `fifo_wr_en`=0, drop counters=0, `discard`=0.
  - Buffers empty.
  - `last_grant`=1, so channel 0 wins the first tie.
- Latency: `recv_en` sampled at edge k → `fifo_wr_en` high in the cycle after edge k+1 (2 clocks) when the arbiter is uncontended.
- With contention, the losing channel waits one extra cycle per competing word.
- `fifo_full` is sampled on the decision edge. The FIFO must absorb one write landing in the cycle `fifo_full` first asserts.
- Simultaneous push and pop on one buffer: both take effect, and the count is unchanged.
- `packet_en` low and `recv_en` high in the same cycle: `discard` clears, and that word is accepted if space exists.
- Reset mid-packet:
  - Buffers are flushed and `discard` is cleared.
  - Words arriving after reset release are accepted without packet resynchronisation. The decoder upstream is reset by the same `sys_rst_n`.

## Configuration

- `GMII_ARB_DROP_CNT_EN` defined: drop counters implemented as above.
- `GMII_ARB_DROP_CNT_EN` undefined:
  - Counter registers are removed and `ch0_drop_cnt`/`ch1_drop_cnt` are tied to 0.
  - Drop and discard behaviour is otherwise identical.

## Test plan

- Single word: ch0 word 0x0ABCDEF1 strobed once, `fifo_full`=0 → one `fifo_wr_en` pulse 2 clocks later with `fifo_din`=0x0ABCDEF1 (bit 29 = 0). No further writes.
- Interleave:
  - Stimulus: both channels, 640 words each at one word per 2 cycles, phase-aligned, `fifo_full`=0.
  - Response: exactly 1280 writes with channel order 0,1,0,1…, each channel's words in original order, both drop counters 0.
- Tie after reset: both channels strobe on the first cycle after reset release → ch0 word written first, ch1 word next cycle.
- Overflow and discard:
  - Stimulus: ch0 streams one word per 2 cycles; `fifo_full` held high for 12 cycles mid-packet.
  - Response: 4 words buffered; the next words are dropped and `ch0_discard`=1; `ch0_drop_cnt` equals the number of strobes from the first drop until `packet_en` falls.
  - After `packet_en` falls, the next packet is fully delivered.
- Reset mid-stream: `sys_rst_n` pulled low for 1 cycle while both buffers hold 3 words → no `fifo_wr_en` after reset; all outputs equal their reset values.
- Macro off: build without `GMII_ARB_DROP_CNT_EN` and repeat the overflow test → identical FIFO traffic and `ch0_discard` behaviour, with `ch0_drop_cnt`=0 throughout.
